// File: rtl/seq_mul_pkg.sv
// Shared widths and FSM state type for the radix-2 shift-add multiplier.
package seq_mul_pkg;

    localparam int unsigned A_W   = 20;
    localparam int unsigned B_W   = 10;
    localparam int unsigned CNT_W = $clog2(B_W);

    typedef enum logic [1:0] {
        StIdle,
        StCalc,
        StDone
    } state_e;

endpackage

// File: rtl/seq_mul_if.sv
// Operand/result handshake bundle for seq_mul; master is the producer/consumer side.
interface seq_mul_if
    import seq_mul_pkg::*;
#(
    parameter int unsigned AW = A_W,
    parameter int unsigned BW = B_W
) ();

    logic               in_valid;
    logic               in_ready;
    logic [AW-1:0]      multiplicand;
    logic [BW-1:0]      multiplier;
    logic               out_valid;
    logic               out_ready;
    logic [AW+BW-1:0]   product;
    logic [AW-1:0]      product_trunc;
    logic               ovf;

    modport master (
        output in_valid, multiplicand, multiplier, out_ready,
        input  in_ready, out_valid, product, product_trunc, ovf
    );

    modport slave (
        input  in_valid, multiplicand, multiplier, out_ready,
        output in_ready, out_valid, product, product_trunc, ovf
    );

endinterface

// File: rtl/seq_mul.sv
// Multi-cycle radix-2 shift-add multiplier, one multiplier bit per cycle.
// SEQ_MUL_SIGNED_EN selects two's-complement operands; default build is unsigned.
module seq_mul
    import seq_mul_pkg::*;
#(
    parameter int unsigned AW = A_W,
    parameter int unsigned BW = B_W
) (
    input  logic     clk,
    input  logic     rst,
    seq_mul_if.slave bus
);

    localparam int unsigned PW   = AW + BW;
    localparam int unsigned CntW = (BW > 1) ? $clog2(BW) : 1;

    state_e          state_q, state_d;
    logic [PW-1:0]   a_q, a_d;
    logic [BW-1:0]   b_q, b_d;
    logic [PW-1:0]   acc_q, acc_d;
    logic [PW-1:0]   prod_q, prod_d;
    logic            ovf_q, ovf_d;
    logic [CntW-1:0] cnt_q, cnt_d;

    logic [PW-1:0]   addend;
    logic            last_step;
    logic            sub_step;
    logic [AW:0]     top_bits;

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        prod_d  = prod_q;
        ovf_d   = ovf_q;
        cnt_d   = cnt_q;

        addend    = a_q << cnt_q;
        last_step = (cnt_q == CntW'(BW - 1));
        top_bits  = '0;
`ifdef SEQ_MUL_SIGNED_EN
        // The multiplier MSB carries negative weight in two's complement.
        sub_step  = last_step;
`else
        sub_step  = 1'b0;
`endif

        unique case (state_q)
            StIdle: begin
                if (bus.in_valid) begin
`ifdef SEQ_MUL_SIGNED_EN
                    a_d = {{BW{bus.multiplicand[AW-1]}}, bus.multiplicand};
`else
                    a_d = {{BW{1'b0}}, bus.multiplicand};
`endif
                    b_d     = bus.multiplier;
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = StCalc;
                end
            end
            StCalc: begin
                if (b_q[cnt_q]) begin
                    acc_d = sub_step ? (acc_q - addend) : (acc_q + addend);
                end
                cnt_d = cnt_q + 1'b1;
                if (last_step) begin
                    cnt_d   = '0;
                    prod_d  = acc_d;
                    state_d = StDone;
`ifdef SEQ_MUL_SIGNED_EN
                    // Fits iff bits [PW-1:AW-1] are a pure sign extension.
                    top_bits = acc_d[PW-1:AW-1];
                    ovf_d    = !((&top_bits[BW:0]) || !(|top_bits[BW:0]));
`else
                    top_bits = {1'b0, acc_d[PW-1:AW]};
                    ovf_d    = |top_bits[BW-1:0];
`endif
                end
            end
            StDone: begin
                if (bus.out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            prod_q  <= '0;
            ovf_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            prod_q  <= prod_d;
            ovf_q   <= ovf_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.in_ready      = (state_q == StIdle);
    assign bus.out_valid     = (state_q == StDone);
    assign bus.product       = prod_q;
    assign bus.product_trunc = prod_q[AW-1:0];
    assign bus.ovf           = ovf_q;

endmodule

// File: tb/tb_seq_mul.sv
// Directed-vector bench for seq_mul; expectations follow SEQ_MUL_SIGNED_EN.
module tb_seq_mul;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    seq_mul_if bus ();

    seq_mul dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

`ifdef SEQ_MUL_SIGNED_EN
    localparam logic [29:0] PNeg17 = 30'h3FFFFFCD;
    localparam logic        ONeg17 = 1'b0;
    localparam logic [29:0] PM1    = 30'h3FFFFF9C;
    localparam logic        OM1    = 1'b0;
`else
    localparam logic [29:0] PNeg17 = 30'h002FFFCD;
    localparam logic        ONeg17 = 1'b1;
    localparam logic [29:0] PM1    = 30'h00018F9C;
    localparam logic        OM1    = 1'b0;
`endif

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_op(input string tag, input logic [19:0] a, input logic [9:0] b,
                          input logic [29:0] exp_p, input logic exp_ovf, input int hold);
        int cyc;
        logic [19:0] exp_t;
        exp_t = exp_p[19:0];
        cyc = 0;
        while (!bus.in_ready && cyc < 40) begin
            tick();
            cyc++;
        end
        check_eq({tag, "_in_ready"}, 32'(bus.in_ready), 32'd1);
        bus.out_ready    = (hold == 0);
        bus.in_valid     = 1'b1;
        bus.multiplicand = a;
        bus.multiplier   = b;
        tick();
        // Scramble operands to show they are sampled only at acceptance.
        bus.in_valid     = 1'b0;
        bus.multiplicand = ~a;
        bus.multiplier   = ~b;
        check_eq({tag, "_busy"}, 32'(bus.in_ready), 32'd0);
        cyc = 0;
        while (!bus.out_valid && cyc < 40) begin
            tick();
            cyc++;
        end
        check_eq({tag, "_latency"}, 32'(cyc), 32'd10);
        check_eq({tag, "_product"}, 32'(bus.product), 32'(exp_p));
        check_eq({tag, "_trunc"}, 32'(bus.product_trunc), 32'(exp_t));
        check_eq({tag, "_ovf"}, 32'(bus.ovf), 32'(exp_ovf));
        for (int i = 0; i < hold; i++) begin
            tick();
            check_eq($sformatf("%s_hold%0d_valid", tag, i), 32'(bus.out_valid), 32'd1);
            check_eq($sformatf("%s_hold%0d_product", tag, i), 32'(bus.product), 32'(exp_p));
            check_eq($sformatf("%s_hold%0d_in_ready", tag, i), 32'(bus.in_ready), 32'd0);
        end
        bus.out_ready = 1'b1;
        tick();
        check_eq({tag, "_post_valid"}, 32'(bus.out_valid), 32'd0);
        check_eq({tag, "_post_in_ready"}, 32'(bus.in_ready), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.in_valid     = 1'b0;
        bus.multiplicand = '0;
        bus.multiplier   = '0;
        bus.out_ready    = 1'b1;
        rst              = 1'b1;
        tick();
        tick();
        check_eq("rst_in_ready", 32'(bus.in_ready), 32'd1);
        check_eq("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check_eq("rst_product", 32'(bus.product), 32'd0);
        check_eq("rst_trunc", 32'(bus.product_trunc), 32'd0);
        check_eq("rst_ovf", 32'(bus.ovf), 32'd0);
        rst = 1'b0;

        run_op("neg17x3", 20'hFFFEF, 10'd3, PNeg17, ONeg17, 0);
        run_op("57x6", 20'd57, 10'd6, 30'h156, 1'b0, 0);
        run_op("100x9", 20'd100, 10'd9, 30'h384, 1'b0, 0);
        run_op("100xm1", 20'd100, 10'h3FF, PM1, OM1, 0);
        run_op("a0x0", 20'd0, 10'h155, 30'd0, 1'b0, 0);
        run_op("b0x0", 20'h12345, 10'd0, 30'd0, 1'b0, 0);
        run_op("big", 20'h7FFFF, 10'h1FF, 30'h0FF7FE01, 1'b1, 0);

        // Reset at CALC count=4 discards the in-flight result.
        bus.in_valid     = 1'b1;
        bus.multiplicand = 20'd57;
        bus.multiplier   = 10'd6;
        tick();
        bus.in_valid = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_eq("midrst_in_ready", 32'(bus.in_ready), 32'd1);
        check_eq("midrst_out_valid", 32'(bus.out_valid), 32'd0);
        check_eq("midrst_product", 32'(bus.product), 32'd0);
        check_eq("midrst_ovf", 32'(bus.ovf), 32'd0);
        for (int i = 0; i < 12; i++) tick();
        check_eq("midrst_stays_idle", 32'(bus.out_valid), 32'd0);

        run_op("hold", 20'd57, 10'd6, 30'h156, 1'b0, 5);
        run_op("after_hold", 20'd100, 10'd9, 30'h384, 1'b0, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
